// File: rtl/lcd_cmd_scheduler.sv
// HD44780 4-bit write scheduler: power-on init, then byte writes arbitrated between two requesters.
// Build option: define LCD_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module lcd_cmd_scheduler #(
    parameter int T_PWRUP = 750000,
    parameter int T_INIT1 = 205000,
    parameter int T_INIT2 = 5000,
    parameter int T_SU    = 2,
    parameter int E_WIDTH = 12,
    parameter int T_NIB   = 50,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       init_done,
    output logic       busy,
    output logic       grant_id,
    output logic       sf_e,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [3:0] lcd_nibble
);

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int NIB_END = T_SU + E_WIDTH + 1;
    localparam int CW      = $clog2(NIB_END + 1);
    localparam int TMAX    = imax(imax(imax(T_PWRUP, T_INIT1), imax(T_INIT2, T_NIB)), imax(T_CMD, T_CLR));
    localparam int TW      = $clog2(TMAX + 1);

    localparam logic [TW-1:0] LIM_PWRUP = TW'(T_PWRUP - 1);
    localparam logic [TW-1:0] LIM_INIT1 = TW'(T_INIT1 - 1);
    localparam logic [TW-1:0] LIM_INIT2 = TW'(T_INIT2 - 1);
    localparam logic [TW-1:0] LIM_NIB   = TW'(T_NIB - 1);
    localparam logic [TW-1:0] LIM_CMD   = TW'(T_CMD - 1);
    localparam logic [TW-1:0] LIM_CLR   = TW'(T_CLR - 1);

    typedef enum logic [3:0] {
        S_PWRUP, S_INIT_NIB, S_INIT_WAIT, S_CFG, S_IDLE,
        S_XFER_HI, S_GAP, S_XFER_LO, S_EXEC_WAIT
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [TW-1:0] tmr_reg;
    logic [TW-1:0] lim_reg;
    logic [1:0]    idx_reg;
    logic          cfg_mode_reg;
    logic [7:0]    byte_reg;
    logic          rs_byte_reg;
    logic          lcd_e_reg;
    logic          lcd_rs_reg;
    logic [3:0]    nibble_reg;
    logic          ready0_reg;
    logic          ready1_reg;
    logic          init_done_reg;
    logic          busy_reg;
    logic          grant_reg;

    logic [CW-1:0] cnt_inc;
    logic          e_next;
    logic          win1;
    logic          long_wait;
    logic [7:0]    cfg_byte;
    logic [TW-1:0] init_lim;

`ifdef LCD_RR_EN
    logic last_reg;
`endif

    always_comb begin
        cnt_inc   = cnt_reg + CW'(1);
        // e is high for cycles T_SU+1 .. T_SU+E_WIDTH of a nibble slot
        e_next    = (cnt_inc >= CW'(T_SU + 1)) && (cnt_inc <= CW'(T_SU + E_WIDTH));
        long_wait = !rs_byte_reg && (byte_reg == 8'h01 || byte_reg == 8'h02 || byte_reg == 8'h03);
`ifdef LCD_RR_EN
        win1 = req1_valid && (!req0_valid || !last_reg);
`else
        win1 = req1_valid && !req0_valid;
`endif
        case (idx_reg)
            2'd0:    cfg_byte = 8'h28;
            2'd1:    cfg_byte = 8'h06;
            2'd2:    cfg_byte = 8'h0C;
            default: cfg_byte = 8'h01;
        endcase
        case (idx_reg)
            2'd0:    init_lim = LIM_INIT1;
            2'd1:    init_lim = LIM_INIT2;
            default: init_lim = LIM_CMD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_PWRUP;
            cnt_reg       <= '0;
            tmr_reg       <= '0;
            lim_reg       <= '0;
            idx_reg       <= '0;
            cfg_mode_reg  <= 1'b0;
            byte_reg      <= '0;
            rs_byte_reg   <= 1'b0;
            lcd_e_reg     <= 1'b0;
            lcd_rs_reg    <= 1'b0;
            nibble_reg    <= '0;
            ready0_reg    <= 1'b0;
            ready1_reg    <= 1'b0;
            init_done_reg <= 1'b0;
            busy_reg      <= 1'b1;
            grant_reg     <= 1'b0;
`ifdef LCD_RR_EN
            last_reg      <= 1'b1;
`endif
        end else begin
            ready0_reg <= 1'b0;
            ready1_reg <= 1'b0;
            case (state_reg)
                S_PWRUP: begin
                    if (tmr_reg == LIM_PWRUP) begin
                        state_reg  <= S_INIT_NIB;
                        cnt_reg    <= CW'(1);
                        idx_reg    <= '0;
                        lcd_rs_reg <= 1'b0;
                        nibble_reg <= 4'h3;
                    end else begin
                        tmr_reg <= tmr_reg + TW'(1);
                    end
                end
                S_INIT_NIB: begin
                    cnt_reg   <= cnt_inc;
                    lcd_e_reg <= e_next;
                    if (cnt_reg == CW'(NIB_END)) begin
                        state_reg <= S_INIT_WAIT;
                        lcd_e_reg <= 1'b0;
                        tmr_reg   <= '0;
                        lim_reg   <= init_lim;
                    end
                end
                S_INIT_WAIT: begin
                    if (tmr_reg == lim_reg) begin
                        if (idx_reg == 2'd3) begin
                            state_reg <= S_CFG;
                            idx_reg   <= '0;
                        end else begin
                            state_reg  <= S_INIT_NIB;
                            idx_reg    <= idx_reg + 2'd1;
                            cnt_reg    <= CW'(1);
                            nibble_reg <= (idx_reg == 2'd2) ? 4'h2 : 4'h3;
                        end
                    end else begin
                        tmr_reg <= tmr_reg + TW'(1);
                    end
                end
                S_CFG: begin
                    state_reg    <= S_XFER_HI;
                    cnt_reg      <= CW'(1);
                    cfg_mode_reg <= 1'b1;
                    byte_reg     <= cfg_byte;
                    rs_byte_reg  <= 1'b0;
                    lcd_rs_reg   <= 1'b0;
                    nibble_reg   <= cfg_byte[7:4];
                end
                S_IDLE: begin
                    if (init_done_reg && (req0_valid || req1_valid)) begin
                        state_reg   <= S_XFER_HI;
                        cnt_reg     <= '0;
                        grant_reg   <= win1;
                        ready0_reg  <= !win1;
                        ready1_reg  <= win1;
                        byte_reg    <= win1 ? req1_data : req0_data;
                        rs_byte_reg <= win1 ? req1_rs : req0_rs;
`ifdef LCD_RR_EN
                        last_reg    <= win1;
`endif
                    end
                end
                S_XFER_HI: begin
                    busy_reg  <= 1'b1;
                    cnt_reg   <= cnt_inc;
                    lcd_e_reg <= e_next;
                    // the accept cycle (cnt 0) only launches the bus setup
                    if (cnt_reg == '0) begin
                        lcd_rs_reg <= rs_byte_reg;
                        nibble_reg <= byte_reg[7:4];
                    end
                    if (cnt_reg == CW'(NIB_END)) begin
                        state_reg <= S_GAP;
                        lcd_e_reg <= 1'b0;
                        tmr_reg   <= '0;
                    end
                end
                S_GAP: begin
                    if (tmr_reg == LIM_NIB) begin
                        state_reg  <= S_XFER_LO;
                        cnt_reg    <= CW'(1);
                        nibble_reg <= byte_reg[3:0];
                    end else begin
                        tmr_reg <= tmr_reg + TW'(1);
                    end
                end
                S_XFER_LO: begin
                    cnt_reg   <= cnt_inc;
                    lcd_e_reg <= e_next;
                    if (cnt_reg == CW'(NIB_END)) begin
                        state_reg <= S_EXEC_WAIT;
                        lcd_e_reg <= 1'b0;
                        tmr_reg   <= '0;
                        lim_reg   <= long_wait ? LIM_CLR : LIM_CMD;
                    end
                end
                S_EXEC_WAIT: begin
                    if (tmr_reg == lim_reg) begin
                        if (cfg_mode_reg && idx_reg != 2'd3) begin
                            state_reg <= S_CFG;
                            idx_reg   <= idx_reg + 2'd1;
                        end else begin
                            state_reg     <= S_IDLE;
                            busy_reg      <= 1'b0;
                            cfg_mode_reg  <= 1'b0;
                            init_done_reg <= init_done_reg | cfg_mode_reg;
                        end
                    end else begin
                        tmr_reg <= tmr_reg + TW'(1);
                    end
                end
                default: state_reg <= S_PWRUP;
            endcase
        end
    end

    assign req0_ready = ready0_reg;
    assign req1_ready = ready1_reg;
    assign init_done  = init_done_reg;
    assign busy       = busy_reg;
    assign grant_id   = grant_reg;
    assign sf_e       = 1'b1;
    assign lcd_e      = lcd_e_reg;
    assign lcd_rs     = lcd_rs_reg;
    assign lcd_rw     = 1'b0;
    assign lcd_nibble = nibble_reg;

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Scoreboard bench for lcd_cmd_scheduler: expected nibbles are queued when stimulus is driven
// and popped on every lcd_e rise; handshake and timing are checked by the main sequence.
module tb_lcd_cmd_scheduler;

    localparam int T_PWRUP = 20;
    localparam int T_INIT1 = 10;
    localparam int T_INIT2 = 5;
    localparam int T_SU    = 2;
    localparam int E_WIDTH = 12;
    localparam int T_NIB   = 3;
    localparam int T_CMD   = 8;
    localparam int T_CLR   = 30;
    localparam int SLOT    = T_SU + E_WIDTH + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req0_rs = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req1_valid = 1'b0, req1_rs = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req0_ready, req1_ready, init_done, busy, grant_id;
    logic       sf_e, lcd_e, lcd_rs, lcd_rw;
    logic [3:0] lcd_nibble;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [4:0] exp_q[$];
    logic       e_q = 1'b0;
    int         e_len = 0;
    logic       last_model = 1'b1;

    lcd_cmd_scheduler #(
        .T_PWRUP(T_PWRUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_SU(T_SU),
        .E_WIDTH(E_WIDTH), .T_NIB(T_NIB), .T_CMD(T_CMD), .T_CLR(T_CLR)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
        .init_done(init_done), .busy(busy), .grant_id(grant_id),
        .sf_e(sf_e), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_nibble(lcd_nibble)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] d);
        exp_q.push_back({rs, d[7:4]});
        exp_q.push_back({rs, d[3:0]});
    endtask

    task automatic push_init();
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h02);
        push_byte(1'b0, 8'h28);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h01);
    endtask

    // Bus monitor: every e pulse is matched against the scoreboard and its width measured
    always @(negedge clk) begin
        if (rst) begin
            e_q   <= 1'b0;
            e_len <= 0;
        end else begin
            if (lcd_e && !e_q) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_nibble", {27'd0, lcd_rs, lcd_nibble}, 32'h1ff);
                end else begin
                    logic [4:0] e;
                    e = exp_q.pop_front();
                    check("nibble", {27'd0, lcd_rs, lcd_nibble}, {27'd0, e});
                end
                check("rw_sfe", {30'd0, lcd_rw, sf_e}, 1);
                e_len <= 1;
            end else if (lcd_e) begin
                e_len <= e_len + 1;
            end
            if (!lcd_e && e_q) check("e_width", e_len, E_WIDTH);
            e_q <= lcd_e;
        end
    end

    task automatic wait_init(output int t_done);
        int falls, t_fall, rdy;
        logic e_prev;
        falls = 0; t_fall = 0; rdy = 0; e_prev = 1'b0; t_done = -1;
        for (int i = 0; i < 3000 && t_done < 0; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) rdy++;
            if (!lcd_e && e_prev) begin
                falls++;
                t_fall = cyc;
            end
            e_prev = lcd_e;
            if (init_done) t_done = cyc;
        end
        check("init_timeout", (t_done >= 0) ? 1 : 0, 1);
        check("init_pulses", falls, 12);
        check("init_done_lat", t_done - t_fall, T_CLR + 1);
        check("ready_in_init", rdy, 0);
    endtask

    task automatic wait_ready(input int exp_w, output int t_rdy);
        int i;
        t_rdy = -1;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) break;
        end
        if (i == 300) begin
            check("ready_timeout", 0, 1);
        end else begin
            t_rdy = cyc;
            check("ready_sel", {30'd0, req1_ready, req0_ready}, exp_w ? 2 : 1);
            check("grant_id", grant_id, exp_w);
            check("busy_at_ready", busy, 0);
            $display("txn t=%0t grant=%0d rs=%0b data=%02h", $time, grant_id,
                     exp_w ? req1_rs : req0_rs, exp_w ? req1_data : req0_data);
        end
    endtask

    task automatic track_byte(input int t_rdy, input int wait_cyc);
        int rise1, falls, t_fall, t_idle;
        logic e_prev;
        rise1 = -1; falls = 0; t_fall = 0; t_idle = -1; e_prev = 1'b0;
        for (int i = 0; i < 500 && t_idle < 0; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("ready_pulse", {30'd0, req1_ready, req0_ready}, 0);
                check("busy_rise", busy, 1);
            end
            if (lcd_e && !e_prev && rise1 < 0) rise1 = cyc;
            if (!lcd_e && e_prev) begin
                falls++;
                t_fall = cyc;
            end
            e_prev = lcd_e;
            if (!busy && falls == 2) t_idle = cyc;
        end
        check("byte_timeout", (t_idle >= 0) ? 1 : 0, 1);
        check("e_latency", rise1 - t_rdy, 1 + T_SU);
        check("exec_wait", t_idle - t_fall, wait_cyc + 1);
    endtask

    function automatic logic pick(input logic v0, input logic v1);
        if (v0 && v1) begin
`ifdef LCD_RR_EN
            return !last_model;
`else
            return 1'b0;
`endif
        end
        return v1 && !v0;
    endfunction

    initial begin
        int t_done, t_rdy, t_prev, w;
        logic [7:0] cur_data[2];

        // reset state, with req0 already asking during init
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h48;
        repeat (3) @(negedge clk);
        check("rst_lcd_e", lcd_e, 0);
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_nibble", lcd_nibble, 0);
        check("rst_rw_sfe", {30'd0, lcd_rw, sf_e}, 1);
        check("rst_ready", {30'd0, req1_ready, req0_ready}, 0);
        check("rst_init_done", init_done, 0);
        check("rst_busy", busy, 1);
        check("rst_grant", grant_id, 0);
        push_init();
        push_byte(1'b1, 8'h48);
        rst = 1'b0;

        wait_init(t_done);
        wait_ready(0, t_rdy);
        check("ready_after_init", t_rdy - t_done, 1);
        req0_valid = 1'b0;
        last_model = 1'b0;
        track_byte(t_rdy, T_CMD);

        // clear command stretches the execution wait and delays the next accept
        req1_valid = 1'b1; req1_rs = 1'b0; req1_data = 8'h01;
        push_byte(1'b0, 8'h01);
        wait_ready(1, t_rdy);
        req1_data = 8'h80;
        push_byte(1'b0, 8'h80);
        track_byte(t_rdy, T_CLR);
        t_prev = t_rdy;
        wait_ready(1, t_rdy);
        check("clr_ready_gap", t_rdy - t_prev, 2 * SLOT + T_NIB + T_CLR + 2);
        req1_valid = 1'b0;
        last_model = 1'b1;
        track_byte(t_rdy, T_CMD);

        // both requesters valid continuously
        cur_data[0] = 8'h30; cur_data[1] = 8'h41;
        req0_rs = 1'b1; req1_rs = 1'b1;
        req0_data = cur_data[0]; req1_data = cur_data[1];
        req0_valid = 1'b1; req1_valid = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 6; k++) begin
            w = int'(pick(1'b1, 1'b1));
            push_byte(1'b1, cur_data[w]);
            wait_ready(w, t_rdy);
            if (k > 0) check("back2back_gap", t_rdy - t_prev, 2 * SLOT + T_NIB + T_CMD + 2);
            last_model = w[0];
            if (k == 5) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end else begin
                cur_data[w] = cur_data[w] + 8'h02;
                if (w == 1) req1_data = cur_data[1];
                else req0_data = cur_data[0];
            end
            track_byte(t_rdy, T_CMD);
            t_prev = t_rdy;
        end

        // reset while e is high in the middle of a byte
        req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h55;
        push_byte(1'b1, 8'h55);
        wait_ready(1, t_rdy);
        req1_valid = 1'b0;
        begin
            int i;
            for (i = 0; i < 30 && !lcd_e; i++) @(negedge clk);
            check("e_seen_before_rst", lcd_e, 1);
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_e_low", lcd_e, 0);
        check("async_init_done", init_done, 0);
        check("async_busy", busy, 1);
        check("async_grant", grant_id, 0);
        exp_q.delete();
        last_model = 1'b1;
        repeat (2) @(negedge clk);
        push_init();
        rst = 1'b0;
        wait_init(t_done);

        // arbitration pointer restarts in favour of req0
        req0_valid = 1'b1; req0_rs = 1'b0; req0_data = 8'h80;
        req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h5A;
        push_byte(1'b0, 8'h80);
        wait_ready(int'(pick(1'b1, 1'b1)), t_rdy);
        req0_valid = 1'b0; req1_valid = 1'b0;
        track_byte(t_rdy, T_CMD);
        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

endmodule
